// File: rtl/booth_r4_mult.sv
// booth_r4_mult: radix-4 Booth sequential multiplier, signed/unsigned, start/busy/done handshake
//   N          : operand width (even, >= 4); K = N/2+1 iterations
//   clk, rst   : clock, asynchronous active-high reset
//   i_start    : request, sampled in IDLE; i_tc/i_min/i_qin captured with it
//   i_tc       : 1 = two's complement operands, 0 = unsigned
//   o_busy     : operation in progress; o_done: one-cycle result pulse
//   o_p        : 2N-bit product, held until next done; o_st: 0 IDLE, 1 CALC, 2 FIN
//   BOOTH_R4_ZERO_SKIP_EN : zero operand jumps straight to FIN (latency 1)
module booth_r4_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_tc,
    input  logic [N-1:0]   i_min,
    input  logic [N-1:0]   i_qin,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_p,
    output logic [1:0]     o_st
);
    localparam int K  = N / 2 + 1;
    localparam int CW = $clog2(K + 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIN = 2'd2} state_t;
    state_t              r_state;
    logic signed [N+3:0] r_a;
    logic [N+1:0]        r_q;
    logic [N+1:0]        r_m;
    logic                r_qres;
    logic [CW-1:0]       r_cnt;
    logic [N+1:0]        w_m_in;
    logic [N+1:0]        w_q_in;
    logic signed [N+3:0] w_m1;
    logic signed [N+3:0] w_m2;
    logic signed [N+3:0] w_dig;
    logic signed [N+3:0] w_sum;
    logic [2:0]          w_rec;
    logic                w_zero;
    assign w_m_in = i_tc ? {{2{i_min[N-1]}}, i_min} : {2'b00, i_min};
    assign w_q_in = i_tc ? {{2{i_qin[N-1]}}, i_qin} : {2'b00, i_qin};
    assign w_m1   = {{2{r_m[N+1]}}, r_m};
    assign w_m2   = {w_m1[N+2:0], 1'b0};
    assign w_rec  = {r_q[1:0], r_qres};
    assign w_dig  = (w_rec == 3'b001 || w_rec == 3'b010) ? w_m1 :
                    (w_rec == 3'b011) ? w_m2 :
                    (w_rec == 3'b100) ? -w_m2 :
                    (w_rec == 3'b101 || w_rec == 3'b110) ? -w_m1 : '0;
    assign w_sum  = r_a + w_dig;
`ifdef BOOTH_R4_ZERO_SKIP_EN
    assign w_zero = (i_min == '0) || (i_qin == '0);
`else
    assign w_zero = 1'b0;
`endif
    assign o_st = r_state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_qres  <= 1'b0;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_p     <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    // a zero-skipped operation leaves A and Q cleared so FIN yields 0
                    r_a     <= '0;
                    r_q     <= w_zero ? '0 : w_q_in;
                    r_m     <= w_m_in;
                    r_qres  <= 1'b0;
                    r_cnt   <= CW'(K);
                    o_busy  <= !w_zero;
                    r_state <= w_zero ? S_FIN : S_CALC;
                end
                S_CALC: begin
                    // arithmetic shift of {A',Q,qres} right by two
                    r_a    <= {{2{w_sum[N+3]}}, w_sum[N+3:2]};
                    r_q    <= {w_sum[1:0], r_q[N+1:2]};
                    r_qres <= r_q[1];
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_FIN;
                end
                S_FIN: begin
                    o_p     <= {r_a[N-3:0], r_q};
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
